alu_operand_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_src_mux.sv | 36 +++
 rtl/alu_operand_stage.sv | 123 ++++++++++++
 tb/tb_alu_operand_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, operand select codes and FSM states for the
// ALU operand sequencing stage.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1011;

    localparam logic SRC_A_RS = 1'b0;
    localparam logic SRC_A_PC = 1'b1;

    localparam logic [1:0] SRC_B_RT   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_IMM4 = 2'b11;

    localparam int CONST_FOUR = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_src_mux.sv
// Operand selection for the ALU: sign-extended and word-shifted
// immediates plus the A and B source muxes.
module alu_src_mux
    import alu_pkg::*;
#(
    parameter int WL = 32
) (
    input  logic          src_a_sel_i,
    input  logic [1:0]    src_b_sel_i,
    input  logic [WL-1:0] rs_i,
    input  logic [WL-1:0] rt_i,
    input  logic [WL-1:0] pc_i,
    input  logic [15:0]   imm16_i,
    output logic [WL-1:0] a_o,
    output logic [WL-1:0] b_o
);

    logic [WL-1:0] sext;
    logic [WL-1:0] sext4;

    assign sext  = {{(WL-16){imm16_i[15]}}, imm16_i};
    // Top two bits fall off; branch offsets never need them.
    assign sext4 = {sext[WL-3:0], 2'b00};

    always_comb begin
        a_o = (src_a_sel_i == SRC_A_PC) ? pc_i : rs_i;
        b_o = rt_i;
        unique case (src_b_sel_i)
            SRC_B_RT:   b_o = rt_i;
            SRC_B_FOUR: b_o = WL'(CONST_FOUR);
            SRC_B_IMM:  b_o = sext;
            SRC_B_IMM4: b_o = sext4;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Latches operands on start, holds them on the ALU for the execute
// window, then captures the result and pulses done.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WL         = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WL-1:0] rs_data,
    input  logic [WL-1:0] rt_data,
    input  logic [WL-1:0] pc,
    input  logic [15:0]   imm16,
    input  logic          src_a_sel,
    input  logic [1:0]    src_b_sel,
    input  logic [3:0]    alu_op_in,
    input  logic [4:0]    shamt_in,
    output logic [WL-1:0] alu_in1,
    output logic [WL-1:0] alu_in2,
    output logic [3:0]    alu_sel,
    output logic [4:0]    shamt,
    input  logic [WL-1:0] alu_result,
    output logic [WL-1:0] result,
    output logic          zero_q,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [WL-1:0] rs_q, rt_q, pc_q;
    logic [15:0]   imm_q;
    logic          sa_q;
    logic [1:0]    sb_q;
    logic [3:0]    op_q;
    logic [4:0]    sh_q;
    logic [WL-1:0] res_q;
    logic          zf_q;
    logic          load;
    logic          capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                    cnt_d   = (alu_op_in == OP_MUL) ?
                              4'(MUL_CYCLES - 1) : 4'd0;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= '0;
            op_q    <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                rs_q  <= rs_data;
                rt_q  <= rt_data;
                pc_q  <= pc;
                imm_q <= imm16;
                sa_q  <= src_a_sel;
                sb_q  <= src_b_sel;
                op_q  <= alu_op_in;
                sh_q  <= shamt_in;
            end
            if (capture) begin
                res_q <= alu_result;
                zf_q  <= (alu_result == '0);
            end
        end
    end

    alu_src_mux #(.WL(WL)) u_mux (
        .src_a_sel_i (sa_q),
        .src_b_sel_i (sb_q),
        .rs_i        (rs_q),
        .rt_i        (rt_q),
        .pc_i        (pc_q),
        .imm16_i     (imm_q),
        .a_o         (alu_in1),
        .b_o         (alu_in2)
    );

    assign alu_sel = op_q;
    assign shamt   = sh_q;
    assign result  = res_q;
    assign zero_q  = zf_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed table, corner sequences and
// random operations against an arithmetic reference.
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int WL      = 32;
    localparam int MUL_CYC = 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] rs_data, rt_data, pc;
    logic [15:0] imm16;
    logic        src_a_sel;
    logic [1:0]  src_b_sel;
    logic [3:0]  alu_op_in;
    logic [4:0]  shamt_in;
    logic [31:0] alu_in1, alu_in2, alu_result, result;
    logic [3:0]  alu_sel;
    logic [4:0]  shamt;
    logic        zero_q, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.WL(WL), .MUL_CYCLES(MUL_CYC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rs_data(rs_data), .rt_data(rt_data), .pc(pc),
        .imm16(imm16), .src_a_sel(src_a_sel),
        .src_b_sel(src_b_sel), .alu_op_in(alu_op_in),
        .shamt_in(shamt_in), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_sel(alu_sel), .shamt(shamt),
        .alu_result(alu_result), .result(result),
        .zero_q(zero_q), .busy(busy), .done(done)
    );

    // Stand-in combinational ALU downstream of the stage.
    function automatic logic [31:0] alu_fn(
        input logic [3:0] op, input logic [31:0] a,
        input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return b << sh;
            4'b0100: return b >> sh;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_sel, alu_in1, alu_in2, shamt);

    typedef struct {
        logic [31:0] rs, rt, pc;
        logic [15:0] imm;
        logic        sa;
        logic [1:0]  sb;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [31:0] e1, e2, eres;
        logic        ez;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [31:0] pcv, input logic [15:0] imm,
        input logic sa, input logic [1:0] sb,
        input logic [3:0] op, input logic [4:0] sh,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic [31:0] eres, input logic ez);
        vec_t v;
        v.rs = rs; v.rt = rt; v.pc = pcv; v.imm = imm;
        v.sa = sa; v.sb = sb; v.op = op; v.sh = sh;
        v.e1 = e1; v.e2 = e2; v.eres = eres; v.ez = ez;
        return v;
    endfunction

    // Operand model from the select rules, using integer arithmetic.
    function automatic void model(input vec_t v,
                                  output logic [31:0] a,
                                  output logic [31:0] b);
        int sx;
        sx = (v.imm >= 16'h8000) ? int'(v.imm) - 65536 : int'(v.imm);
        a  = v.sa ? v.pc : v.rs;
        case (v.sb)
            2'd0:    b = v.rt;
            2'd1:    b = 32'd4;
            2'd2:    b = 32'(sx);
            default: b = 32'(sx * 4);
        endcase
    endfunction

    task automatic drive(input vec_t v);
        rs_data = v.rs; rt_data = v.rt; pc = v.pc; imm16 = v.imm;
        src_a_sel = v.sa; src_b_sel = v.sb;
        alu_op_in = v.op; shamt_in = v.sh;
    endtask

    task automatic scramble();
        rs_data = $urandom; rt_data = $urandom; pc = $urandom;
        imm16 = 16'($urandom); src_a_sel = 1'($urandom);
        src_b_sel = 2'($urandom); alu_op_in = 4'($urandom);
        shamt_in = 5'($urandom);
    endtask

    task automatic run(input vec_t v, input string nm);
        int  lat, explat;
        bit  seen;
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        chk({nm, ".done0"}, 32'(done), 32'd0);
        chk({nm, ".in1"}, alu_in1, v.e1);
        chk({nm, ".in2"}, alu_in2, v.e2);
        chk({nm, ".sel"}, 32'(alu_sel), 32'(v.op));
        chk({nm, ".shamt"}, 32'(shamt), 32'(v.sh));
        explat = (v.op == OP_MUL) ? MUL_CYC : 1;
        lat = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
            chk({nm, ".in1hold"}, alu_in1, v.e1);
        end
        chk({nm, ".lat"}, 32'(lat), 32'(explat));
        chk({nm, ".res"}, result, v.eres);
        chk({nm, ".zero"}, 32'(zero_q), 32'(v.ez));
        @(posedge clk); #1;
        chk({nm, ".done1"}, 32'(done), 32'd0);
        chk({nm, ".idle"}, 32'(busy), 32'd0);
        chk({nm, ".reshold"}, result, v.eres);
        chk({nm, ".in2hold"}, alu_in2, v.e2);
    endtask

    vec_t tab[10];

    initial begin
        vec_t        v, b;
        logic [31:0] a1, a2;
        int          dcnt;

        tab[0] = mk(5, 7, 0, 0, 0, 2'd0, OP_ADD, 0,
                    5, 7, 12, 0);
        tab[1] = mk(32'h1234, 32'h1234, 0, 0, 0, 2'd0, OP_SUB, 0,
                    32'h1234, 32'h1234, 0, 1);
        tab[2] = mk(0, 0, 32'h100, 16'hFFFE, 1, 2'd3, OP_ADD, 0,
                    32'h100, 32'hFFFFFFF8, 32'hF8, 0);
        tab[3] = mk(3, 4, 0, 0, 0, 2'd0, OP_MUL, 0,
                    3, 4, 12, 0);
        tab[4] = mk(0, 0, 32'h200, 0, 1, 2'd1, OP_ADD, 0,
                    32'h200, 4, 32'h204, 0);
        tab[5] = mk(0, 0, 0, 16'h8000, 0, 2'd2, OP_OR, 0,
                    0, 32'hFFFF8000, 32'hFFFF8000, 0);
        tab[6] = mk(1, 2, 0, 0, 0, 2'd0, 4'b1100, 0,
                    1, 2, 0, 1);
        tab[7] = mk(9, 1, 0, 0, 0, 2'd0, OP_SLL, 4,
                    9, 1, 16, 0);
        tab[8] = mk(0, 0, 0, 16'h7FFF, 0, 2'd3, OP_ADD, 0,
                    0, 32'h1FFFC, 32'h1FFFC, 0);
        tab[9] = mk(32'hFFFFFFFF, 2, 0, 0, 0, 2'd0, OP_MUL, 0,
                    32'hFFFFFFFF, 2, 32'hFFFFFFFE, 0);

        rst = 1'b1;
        start = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.res", result, 0);
        chk("rst.zero", 32'(zero_q), 0);
        chk("rst.in1", alu_in1, 0);
        chk("rst.in2", alu_in2, 0);
        chk("rst.sel", 32'(alu_sel), 0);
        chk("rst.shamt", 32'(shamt), 0);

        for (int i = 0; i < 10; i++) begin
            run(tab[i], $sformatf("tab%0d", i));
        end

        // Reset mid-EXEC of a multiply.
        drive(tab[3]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        dcnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        rst = 1'b0;
        chk("mid.busy", 32'(busy), 0);
        chk("mid.res", result, 0);
        chk("mid.zero", 32'(zero_q), 0);
        chk("mid.in1", alu_in1, 0);
        repeat (5) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        chk("mid.nodone", 32'(dcnt), 0);
        chk("mid.idle", 32'(busy), 0);

        // Start held through EXEC and DONE is ignored.
        v = mk(10, 20, 0, 0, 0, 2'd0, OP_ADD, 0, 10, 20, 30, 0);
        b = mk(100, 200, 0, 0, 0, 2'd0, OP_ADD, 0,
               100, 200, 300, 0);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        drive(b);
        dcnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        start = 1'b0;
        chk("b2b.busy", 32'(busy), 0);
        chk("b2b.done", 32'(done), 0);
        chk("b2b.ndone", 32'(dcnt), 1);
        chk("b2b.res", result, 30);
        chk("b2b.in1", alu_in1, 10);
        run(b, "b2b.next");

        for (int i = 0; i < 40; i++) begin
            v.rs  = $urandom;
            v.rt  = ($urandom_range(0, 3) == 0) ? v.rs : $urandom;
            v.pc  = $urandom;
            v.imm = 16'($urandom);
            v.sa  = 1'($urandom);
            v.sb  = 2'($urandom);
            v.op  = 4'($urandom_range(0, 15));
            v.sh  = 5'($urandom);
            model(v, a1, a2);
            v.e1   = a1;
            v.e2   = a2;
            v.eres = alu_fn(v.op, a1, a2, v.sh);
            v.ez   = (v.eres == 32'd0);
            run(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
